// File: rtl/syn_fifo_pkg.sv
// Shared definitions for the syn_fifo family.
//   FWFT_OFF / FWFT_ON : read-mode selector values
//   clog2_depth        : bits needed to hold a count of 0..depth
//   thresh_ok          : legality check for depth / almost thresholds
package syn_fifo_pkg;

   localparam int FWFT_OFF = 0;
   localparam int FWFT_ON  = 1;

   function automatic int clog2_depth(input int depth);
      int unsigned w;
      w = 1;
      while ((1 << w) <= depth) w++;
      return int'(w);
   endfunction

   function automatic bit thresh_ok(input int depth, input int af, input int ae);
      return (depth >= 2) && (af >= 1) && (af <= depth) && (ae >= 0) && (ae < depth);
   endfunction

endpackage

// File: rtl/syn_fifo_ptr.sv
// Modulo-DEPTH index counter used for the FIFO read and write pointers.
//   clk  : clock, rising edge
//   srst : synchronous active-high reset, ptr -> 0
//   inc  : advance pointer by one, wrapping DEPTH-1 -> 0
//   ptr  : current index 0..DEPTH-1
module syn_fifo_ptr #(
   parameter int DEPTH     = 8,
   parameter int PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 inc,
   output logic [PTR_WIDTH-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (srst) begin
         ptr <= '0;
      end else if (inc) begin
         // explicit wrap: DEPTH need not be a power of two
         if (ptr == PTR_WIDTH'(DEPTH - 1)) ptr <= '0;
         else                              ptr <= ptr + 1'b1;
      end
   end

endmodule

// File: rtl/syn_fifo_ext.sv
// Single-clock FIFO, arbitrary depth, programmable almost thresholds,
// selectable standard / first-word-fall-through read, sticky error flags.
//   clk, srst            : clock and synchronous active-high reset
//   wen, data_in         : write request and data
//   ren, data_out        : read request (pop) and read data
//   full, empty          : used == DEPTH / used == 0
//   almost_full/_empty   : used >= AF_THRESH / used <= AE_THRESH
//   used                 : stored word count
//   overflow, underflow  : sticky rejected-write / rejected-read flags
//   err_clr              : clears the sticky flags
module syn_fifo_ext
   import syn_fifo_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 8,
   parameter int AF_THRESH  = DEPTH - 1,
   parameter int AE_THRESH  = 1,
   parameter int FWFT       = FWFT_OFF,
   parameter int USED_WIDTH = clog2_depth(DEPTH)
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  wen,
   input  logic [WIDTH-1:0]      data_in,
   input  logic                  ren,
   output logic [WIDTH-1:0]      data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [USED_WIDTH-1:0] used,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam int PTR_WIDTH = $clog2(DEPTH);

   if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
      $error("syn_fifo_ext: illegal DEPTH / AF_THRESH / AE_THRESH");
   end

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic                  rd_acc;
   logic                  wr_acc;
   logic [USED_WIDTH-1:0] used_next;

   // A read at full frees a slot in the same cycle, so pass-through is legal.
   // At empty a simultaneous write is still taken; only the read is refused.
   always_comb begin
      rd_acc    = ren && !empty;
      wr_acc    = wen && (!full || rd_acc);
      used_next = used + USED_WIDTH'(wr_acc) - USED_WIDTH'(rd_acc);
   end

   syn_fifo_ptr #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_wr_ptr (
      .clk  (clk),
      .srst (srst),
      .inc  (wr_acc),
      .ptr  (wr_ptr)
   );

   syn_fifo_ptr #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_rd_ptr (
      .clk  (clk),
      .srst (srst),
      .inc  (rd_acc),
      .ptr  (rd_ptr)
   );

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (!srst && wr_acc) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         used         <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         used         <= used_next;
         full         <= (used_next == USED_WIDTH'(DEPTH));
         empty        <= (used_next == '0);
         almost_full  <= (used_next >= USED_WIDTH'(AF_THRESH));
         almost_empty <= (used_next <= USED_WIDTH'(AE_THRESH));
         // a new error event in the same cycle as err_clr keeps the flag set
         if (wen && !wr_acc) overflow <= 1'b1;
         else if (err_clr)   overflow <= 1'b0;
         if (ren && !rd_acc) underflow <= 1'b1;
         else if (err_clr)   underflow <= 1'b0;
      end
   end

   if (FWFT == FWFT_ON) begin : g_fwft
      // head of queue is always presented; zero while nothing is stored
      assign data_out = empty ? '0 : mem[rd_ptr];
   end else begin : g_std
      always_ff @(posedge clk) begin
         if (srst)        data_out <= '0;
         else if (rd_acc) data_out <= mem[rd_ptr];
      end
   end

endmodule

// File: doc/syn_fifo_ext.md
Name: syn_fifo_ext

Overview:
Parametrised successor to syn_fifo. It is a single-clock FIFO with arbitrary (non-power-of-two) depth, programmable almost-full/almost-empty thresholds, a selectable read mode (standard registered read or first-word fall-through), and sticky overflow/underflow error flags. It sits between producer and consumer stages in the same clock domain and can replace syn_fifo where flow control needs early warning.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 8, number of storage entries (>=2, any integer)
AF_THRESH, DEPTH-1, almost_full asserts when used >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserts when used <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard read (1-cycle latency); 1 = first-word fall-through
USED_WIDTH, $clog2(DEPTH+1), width of the used count (derived; do not override)

Ports:
clk  in  1  clock, all logic on rising edge
srst  in  1  synchronous reset, active-high
wen  in  1  write request
data_in  in  WIDTH  write data, sampled with wen
ren  in  1  read request / pop
data_out  out  WIDTH  read data
full  out  1  used == DEPTH
empty  out  1  used == 0
almost_full  out  1  used >= AF_THRESH
almost_empty  out  1  used <= AE_THRESH
used  out  USED_WIDTH  current number of stored words
overflow  out  1  sticky: write attempted while full and not accepted
underflow  out  1  sticky: read attempted while empty
err_clr  in  1  clears overflow/underflow

Behaviour:
- Interface: reset srst, synchronous, active-high; clock clk.
- Reset, sampled at a rising edge while srst=1:
  - Pointers and used go to 0. empty=1, full=0, almost_empty=1, almost_full=0.
  - data_out=0, overflow=0, underflow=0.
  - Storage contents are not cleared. Any data present mid-operation is discarded.
  - wen, ren and err_clr are ignored while srst=1.
- Accept rules, per cycle:
  - Read is accepted when ren=1 and empty=0.
  - Write is accepted when wen=1 and (full=0, or full=1 with a read accepted the same cycle). Pass-through at full is allowed.
  - At empty, simultaneous wen and ren: the write is accepted, the read is rejected, and underflow is set.
- Count and flags:
  - used_next = used + write_acc - read_acc.
  - All flags are registered, computed from used_next, and change on the same edge as used.
- Pointers:
  - Write and read pointers are indices 0..DEPTH-1.
  - Each increments on acceptance and wraps explicitly from DEPTH-1 to 0. Do not rely on power-of-two overflow.
- FWFT=0:
  - On an accepted read, data_out registers mem[rd_ptr] at that edge, so data is valid the cycle after ren.
  - data_out holds its value otherwise, including on a rejected read.
- FWFT=1:
  - data_out equals the oldest stored word whenever empty=0. Content is undefined-but-stable while empty.
  - An accepted ren pops, and the next word appears after that edge.
  - Write-to-data visibility is 1 cycle after the write edge, coincident with empty deasserting.
- Errors:
  - overflow sets on wen=1 with write rejected.
  - underflow sets on ren=1 with read rejected.
  - Both hold until err_clr=1 or srst. If an error event and err_clr occur in the same cycle, set wins.
- Write-then-read ordering is strict FIFO. No data is corrupted on a rejected access.
- Parameter checks: elaboration error if AF_THRESH is not in 1..DEPTH, if AE_THRESH >= DEPTH, or if DEPTH < 2.

Decomposition:
- Package syn_fifo_pkg holds:
  - localparam constants FWFT_OFF=0 and FWFT_ON=1.
  - A function clog2_depth(DEPTH) for USED_WIDTH.
  - A threshold-check function shared by the FIFO family.
- Sub-module syn_fifo_ptr, instantiated twice (read and write): modulo-DEPTH pointer with inc and srst, output ptr.
- The storage array stays inline as a register array.

Test Plan:
1. DEPTH=6, AF_THRESH=5, AE_THRESH=1, FWFT=0: write 1..6 on consecutive cycles -> almost_empty drops when used=2, almost_full=1 at used=5, full=1 at used=6. Then read 6 times -> data_out=1..6, each one cycle after its ren, and empty=1 after the last read.
2. Full FIFO (DEPTH=6): wen with data 7 and no ren -> write ignored, overflow=1, used stays 6. Then wen=7 and ren together -> 1 is read, 7 is stored, used=6. err_clr=1 -> overflow=0.
3. Empty FIFO: ren=1 -> underflow=1, data_out unchanged. Then wen=0xAA and ren together -> write accepted, used=1, underflow stays 1.
4. Wrap-around: DEPTH=6, random wen/ren at about 50% each for 2000 cycles against a scoreboard -> every read matches the in-order counter, used matches the model, no overflow or underflow is ever flagged when the bench respects full/empty.
5. FWFT=1: write 0x11 at cycle N -> empty=0 and data_out=0x11 at N+1. With 0x22 also written, a ren at N+2 makes data_out=0x22 at N+3.
6. Reset mid-operation with used=4 -> after srst, used=0, empty=1, overflow=0, data_out=0. The next written word, 0x55, reads back first.
